// File: rtl/loop_controller_if.sv
// Execute-stage to loop-controller bus.
// The master presents bracket opcodes. The slave returns the handshake, the PC redirect and status.
interface loop_controller_if #(
  parameter int IA_WIDTH = 12,
  parameter int SP_WIDTH = 4
);
  logic                op_valid;
  logic                op_ready;
  logic                op_open;
  logic                op_close;
  logic [IA_WIDTH-1:0] op_pc;
  logic                zero;
  logic                pc_load;
  logic [IA_WIDTH-1:0] pc_target;
  logic                flush;
  logic                skip;
  logic [SP_WIDTH:0]   level;
  logic                err;

  modport master (
    output op_valid, op_open, op_close, op_pc, zero,
    input  op_ready, pc_load, pc_target, flush, skip, level, err
  );

  modport slave (
    input  op_valid, op_open, op_close, op_pc, zero,
    output op_ready, pc_load, pc_target, flush, skip, level, err
  );
endinterface

// File: rtl/loop_controller.sv
// Bracket sequencer: keeps a return-address stack of open loops.
// It redirects the PC on a ']' whose cell is non-zero, and skips forward on a '[' whose cell is zero.
module loop_controller #(
  parameter int IA_WIDTH    = 12,
  parameter int STACK_DEPTH = 16,
  parameter int SP_WIDTH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  loop_controller_if.slave  bus
);
  typedef enum logic [1:0] {RUN, JUMP, SKIP, HALT} state_e;

  localparam logic [SP_WIDTH:0] FULL = (SP_WIDTH+1)'(STACK_DEPTH);

  state_e              state_q, state_d;
  logic [SP_WIDTH:0]   level_q, level_d;
  logic [IA_WIDTH-1:0] depth_q, depth_d;
  logic [IA_WIDTH-1:0] pc_target_q, pc_target_d;
  logic                err_q, err_d;
  logic [IA_WIDTH-1:0] stack_q [STACK_DEPTH];

  logic                push;
  logic                fire, is_open, is_close;
  logic [SP_WIDTH-1:0] wr_idx, top_idx;

  // Both flags set at once decode as an ordinary opcode.
  assign is_open  = bus.op_open  & ~bus.op_close;
  assign is_close = bus.op_close & ~bus.op_open;
  assign fire     = bus.op_valid & bus.op_ready;
  assign wr_idx   = level_q[SP_WIDTH-1:0];
  assign top_idx  = SP_WIDTH'(level_q - 1'b1);

  assign bus.op_ready  = (state_q == RUN) || (state_q == SKIP);
  assign bus.pc_load   = (state_q == JUMP);
  assign bus.flush     = (state_q == JUMP);
  assign bus.skip      = (state_q == SKIP);
  assign bus.pc_target = pc_target_q;
  assign bus.level     = level_q;
  assign bus.err       = err_q;

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    depth_d     = depth_q;
    pc_target_d = pc_target_q;
    err_d       = err_q;
    push        = 1'b0;
    case (state_q)
      RUN: if (fire) begin
        if (is_open) begin
          if (bus.zero) begin
            depth_d = IA_WIDTH'(1);
            state_d = SKIP;
          end else if (level_q == FULL) begin
            err_d   = 1'b1;
            state_d = HALT;
          end else begin
            push    = 1'b1;
            level_d = level_q + 1'b1;
          end
        end else if (is_close) begin
          if (level_q == '0) begin
            err_d   = 1'b1;
            state_d = HALT;
          end else if (!bus.zero) begin
            // The loop stays open; the re-executed '[' is skipped by targeting top+1.
            pc_target_d = stack_q[top_idx] + 1'b1;
            state_d     = JUMP;
          end else begin
            level_d = level_q - 1'b1;
          end
        end
      end
      JUMP: state_d = RUN;
      SKIP: if (fire) begin
        if (is_open) begin
          depth_d = depth_q + 1'b1;
        end else if (is_close) begin
          depth_d = depth_q - 1'b1;
          if (depth_q == IA_WIDTH'(1)) state_d = RUN;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      level_q     <= '0;
      depth_q     <= '0;
      pc_target_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      depth_q     <= depth_d;
      pc_target_q <= pc_target_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else if (push) begin
      stack_q[wr_idx] <= bus.op_pc;
    end
  end
endmodule

// File: tb/tb_loop_controller.sv
// Scoreboard bench for loop_controller.
// Jump targets are queued when a ']' is driven, and popped when pc_load fires.
module tb_loop_controller;
  localparam int IA  = 12;
  localparam int SD  = 16;
  localparam int SPW = 4;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [IA-1:0] exp_q [$];

  loop_controller_if #(.IA_WIDTH(IA), .SP_WIDTH(SPW)) bus ();

  loop_controller #(.IA_WIDTH(IA), .STACK_DEPTH(SD), .SP_WIDTH(SPW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every redirect must match the oldest queued target.
  always @(negedge clk) begin
    if (bus.pc_load === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_pc_load", 32'(bus.pc_target), 32'hFFFF_FFFF);
      else                   chk("pc_target", 32'(bus.pc_target), 32'(exp_q.pop_front()));
      chk("flush_with_load", 32'(bus.flush), 1);
    end
  end

  // The task returns 1 ns after the transfer edge.
  task automatic send(input logic o, input logic c, input logic [IA-1:0] pc, input logic z);
    int n = 0;
    @(negedge clk);
    while (bus.op_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.op_ready !== 1'b1) chk("ready_timeout", 0, 1);
    bus.op_valid = 1'b1;
    bus.op_open  = o;
    bus.op_close = c;
    bus.op_pc    = pc;
    bus.zero     = z;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    bus.op_open  = 1'b0;
    bus.op_close = 1'b0;
    bus.zero     = 1'b0;
  endtask

  // A 1 ns pulse that never straddles a clock edge.
  task automatic rst_pulse();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 32'(bus.op_ready), 1);
    chk({tag, "_level"}, 32'(bus.level), 0);
    chk({tag, "_err"},   32'(bus.err), 0);
    chk({tag, "_skip"},  32'(bus.skip), 0);
    chk({tag, "_load"},  32'(bus.pc_load), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    bus.op_valid = 1'b0;
    bus.op_open  = 1'b0;
    bus.op_close = 1'b0;
    bus.op_pc    = '0;
    bus.zero     = 1'b0;
    #12;
    reset = 1'b0;
    chk_idle("rst");
    chk("rst_flush", 32'(bus.flush), 0);
    chk("rst_target", 32'(bus.pc_target), 0);

    // Push at 5 then an immediate ']' with a non-zero cell: jump to 6.
    send(1'b1, 1'b0, 12'd5, 1'b0);
    chk("t1_level_push", 32'(bus.level), 1);
    exp_q.push_back(12'd6);
    send(1'b0, 1'b1, 12'd9, 1'b0);
    chk("t1_jump_ready", 32'(bus.op_ready), 0);
    chk("t1_jump_load", 32'(bus.pc_load), 1);
    chk("t1_jump_flush", 32'(bus.flush), 1);
    @(posedge clk); #1;
    chk("t1_after_ready", 32'(bus.op_ready), 1);
    chk("t1_after_load", 32'(bus.pc_load), 0);
    chk("t1_loop_open", 32'(bus.level), 1);
    rst_pulse();
    chk_idle("t1_rst");

    // A ']' with a zero cell closes the loop in place.
    send(1'b1, 1'b0, 12'd5, 1'b0);
    send(1'b0, 1'b1, 12'd9, 1'b1);
    chk("t2_level", 32'(bus.level), 0);
    chk("t2_ready", 32'(bus.op_ready), 1);
    chk("t2_load", 32'(bus.pc_load), 0);

    // Both flags set is not a bracket.
    send(1'b1, 1'b1, 12'd40, 1'b0);
    chk_idle("both");

    // Forward skip across a nested pair.
    send(1'b1, 1'b0, 12'd20, 1'b1);
    chk("t3_skip_on", 32'(bus.skip), 1);
    chk("t3_level0", 32'(bus.level), 0);
    send(1'b1, 1'b0, 12'd21, 1'b0);
    send(1'b0, 1'b0, 12'd22, 1'b0);
    send(1'b0, 1'b1, 12'd23, 1'b0);
    chk("t3_inner_close", 32'(bus.skip), 1);
    send(1'b0, 1'b0, 12'd24, 1'b0);
    send(1'b0, 1'b1, 12'd25, 1'b0);
    chk_idle("t3_done");

    // Overflow on the 17th open.
    for (int i = 0; i < SD; i++) send(1'b1, 1'b0, 12'(100 + i), 1'b0);
    chk("t4_full", 32'(bus.level), SD);
    chk("t4_no_err", 32'(bus.err), 0);
    send(1'b1, 1'b0, 12'd200, 1'b0);
    chk("t4_err", 32'(bus.err), 1);
    chk("t4_ready", 32'(bus.op_ready), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("t4_err_hold", 32'(bus.err), 1);
    chk("t4_ready_hold", 32'(bus.op_ready), 0);
    chk("t4_level_hold", 32'(bus.level), SD);
    chk("t4_load", 32'(bus.pc_load), 0);
    rst_pulse();
    chk_idle("t4_rst");

    // Unmatched ']', then a 1 ns reset pulse clears the halt.
    send(1'b0, 1'b1, 12'd30, 1'b1);
    chk("t5_err", 32'(bus.err), 1);
    chk("t5_ready", 32'(bus.op_ready), 0);
    chk("t5_level", 32'(bus.level), 0);
    rst_pulse();
    chk_idle("t5_rst");

    // Target wraps; a reset during the jump cancels the redirect.
    send(1'b1, 1'b0, 12'hFFF, 1'b0);
    send(1'b0, 1'b1, 12'h010, 1'b0);
    chk("t6_load", 32'(bus.pc_load), 1);
    chk("t6_wrap", 32'(bus.pc_target), 0);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_async_load", 32'(bus.pc_load), 0);
    chk("t6_async_flush", 32'(bus.flush), 0);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("t6_no_reload", 32'(bus.pc_load), 0);
    end
    chk_idle("t6_end");

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/loop_controller.md
Name: loop_controller

Overview:
Sequences the program counter for the bracket instructions '[' and ']'. The execute stage presents each bracket, its instruction address and the current-cell-zero flag. This block keeps a return-address stack of open loops and schedules PC reloads and pipeline flushes. When '[' sees a zero cell, it runs a forward-skip scan over the fetched opcodes, tracking nesting depth until the matching ']'.

Parameters:
IA_WIDTH, 12, instruction address width
STACK_DEPTH, 16, number of open-loop entries (power of two, >=2)
SP_WIDTH, 4, log2(STACK_DEPTH)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
op_valid  in  1  an opcode is presented this cycle
op_ready  out  1  controller accepts the opcode this cycle
op_open  in  1  presented opcode is '['
op_close  in  1  presented opcode is ']'
op_pc  in  IA_WIDTH  address of the presented opcode
zero  in  1  current data cell == 0; valid with op_valid
pc_load  out  1  one-cycle pulse: load pc_target into PC
pc_target  out  IA_WIDTH  jump target, valid while pc_load=1
flush  out  1  one-cycle pulse coincident with pc_load: discard fetched/decoded opcodes
skip  out  1  high in SKIP: downstream stages treat opcodes as no-ops
level  out  SP_WIDTH+1  current stack occupancy, 0..STACK_DEPTH
err  out  1  sticky: stack overflow or unmatched ']'

Behaviour:
- Transfer occurs on op_valid & op_ready. Opcodes with neither flag set pass with no effect outside SKIP.
- op_open and op_close both high: treated as a non-bracket opcode.
- States: RUN, JUMP, SKIP, HALT.
- Reset (async) values: state=RUN, stack empty, level=0, skip depth=0, op_ready=1, pc_load=0, pc_target=0, flush=0, skip=0, err=0.
- op_ready = 1 in RUN and SKIP, 0 in JUMP and HALT. It is a combinational function of state only, with no path from op_valid.
- RUN, '[' and zero=0:
  - If level==STACK_DEPTH: err<=1, go to HALT.
  - Otherwise push op_pc and increment level.
- RUN, '[' and zero=1: skip depth<=1, go to SKIP. The stack is unchanged.
- RUN, ']' with level==0: err<=1, go to HALT.
- RUN, ']' and zero=0:
  - pc_target<=top+1, modulo 2^IA_WIDTH.
  - Go to JUMP. The stack is unchanged; the loop stays open.
- RUN, ']' and zero=1: pop, decrement level, stay in RUN.
- JUMP: lasts exactly one cycle. pc_load=1 and flush=1 during it, then return to RUN.
  - Latency: a ']' accepted in cycle N gives pc_load in cycle N+1, and op_ready=1 again in N+2.
- SKIP: skip=1 and every accepted opcode is consumed.
  - '[' increments skip depth.
  - ']' with depth>1 decrements it.
  - ']' with depth==1 sets depth<=0 and returns to RUN; that ']' is not executed.
  - zero is ignored. No push or pop occurs in SKIP.
- SKIP depth counter is IA_WIDTH bits wide and cannot overflow for a program of 2^IA_WIDTH bytes.
- HALT: terminal until reset. op_ready=0, pc_load=0, flush=0, skip=0, err=1; level holds its value.
- Push-then-jump in consecutive transfers: when '[' is pushed at cycle N and ']' arrives at N+1, the ']' must see the new top (bypass or a registered stack is acceptable, but the result must be correct).
- op_valid=0 in any state causes no state change except the JUMP -> RUN exit.
- Reset asserted mid-JUMP or mid-SKIP aborts immediately and returns to the reset values; pc_load is not asserted after reset.

Test Plan:
- '[' @pc=5, zero=0; then ']' @pc=9, zero=0 -> level 0->1; one cycle after the ']' transfer pc_load=1, flush=1, pc_target=6; op_ready=0 for exactly that one cycle.
- Same sequence but ']' with zero=1 -> no pc_load, level 1->0, state stays RUN.
- '[' zero=1, then opcodes '[', '+', ']', '>', ']' -> skip=1 from the cycle after the first '['; skip=0 after the final ']'; level stays 0; no pc_load.
- 16 nested '[' with zero=0, then a 17th '[' -> level=16, err=1, op_ready=0 and held until reset; no pc_load.
- ']' with empty stack -> err=1, HALT. Then pulse reset for 1 ns with no clock edge -> err=0, op_ready=1, level=0.
- '[' @pc=12'hFFF, zero=0; then ']' zero=0 -> pc_target=12'h000 (wrap). Reset asserted during the JUMP cycle -> pc_load returns to 0 asynchronously and never re-asserts.
